// File: rtl/mean_update_engine.sv
// k-means mean update: divides per-cluster RGB sums by pixel counts with a
// serial restoring divider and commits all cluster means atomically.
module mean_update_engine #(
    parameter int T = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [72*T-1:0]   accumolator,
    input  logic [12*T-1:0]   counters,
    input  logic              seed_valid,
    input  logic [3:0]        seed_index,
    input  logic [23:0]       seed_mean,
    input  logic              seed_clear,
    output logic [16*24-1:0]  meanOut,
    output logic [15:0]       enabled,
    output logic              busy,
    output logic              done,
    output logic              changed
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_DIV,
        S_WRITE,
        S_COMMIT
    } state_e;

    localparam logic [3:0] LAST = 4'(T - 1);
    localparam logic [4:0] T_W  = 5'(T);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [1:0]        chan_q, chan_d;
    logic [4:0]        bit_q, bit_d;
    logic [11:0]       rem_q, rem_d;
    logic [23:0]       dvd_q, dvd_d;
    logic [23:0]       quo_q, quo_d;
    logic [15:0][23:0] mean_q, mean_d;
    logic [15:0][23:0] shadow_q, shadow_d;
    logic [15:0]       en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              changed_q, changed_d;

    logic [1:0]        sel_chan;
    int                sum_off;
    int                cnt_off;
    logic [23:0]       cur_sum;
    logic [11:0]       cur_cnt;
    logic [11:0]       st_rem_in;
    logic [23:0]       st_dvd_in;
    logic [23:0]       st_quo_in;
    logic [12:0]       trial;
    logic              ge;
    logic [11:0]       st_rem;
    logic [23:0]       st_dvd;
    logic [23:0]       st_quo;
    logic [7:0]        sat_q;

    // Operand fetch: SCAN starts channel 0, WRITE preloads the next channel.
    always_comb begin
        sel_chan = (state_q == S_WRITE) ? chan_q + 2'd1 : 2'd0;
        sum_off  = int'(idx_q) * 72 + int'(sel_chan) * 24;
        cnt_off  = int'(idx_q) * 12;
        cur_sum  = accumolator[sum_off +: 24];
        cur_cnt  = counters[cnt_off +: 12];
    end

    // One restoring step; SCAN folds in the first step of channel 0.
    always_comb begin
        st_rem_in = (state_q == S_SCAN) ? 12'd0 : rem_q;
        st_dvd_in = (state_q == S_SCAN) ? cur_sum : dvd_q;
        st_quo_in = (state_q == S_SCAN) ? 24'd0 : quo_q;
        trial     = {st_rem_in, st_dvd_in[23]};
        ge        = trial >= {1'b0, cur_cnt};
        st_rem    = ge ? 12'(trial - {1'b0, cur_cnt}) : trial[11:0];
        st_dvd    = {st_dvd_in[22:0], 1'b0};
        st_quo    = {st_quo_in[22:0], ge};
        sat_q     = (|quo_q[23:8]) ? 8'hFF : quo_q[7:0];
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        chan_d    = chan_q;
        bit_d     = bit_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        quo_d     = quo_q;
        mean_d    = mean_q;
        shadow_d  = shadow_q;
        en_d      = en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        changed_d = changed_q;
        unique case (state_q)
            S_IDLE: begin
                if (seed_clear) begin
                    mean_d   = '0;
                    shadow_d = '0;
                    en_d     = '0;
                end else if (seed_valid && ({1'b0, seed_index} < T_W)) begin
                    mean_d[seed_index]   = seed_mean;
                    shadow_d[seed_index] = seed_mean;
                    en_d[seed_index]     = 1'b1;
                end
                if (start) begin
                    state_d = S_SCAN;
                    idx_d   = 4'd0;
                    busy_d  = 1'b1;
                end
            end
            S_SCAN: begin
                if (!en_q[idx_q] || cur_cnt == 12'd0) begin
                    shadow_d[idx_q] = mean_q[idx_q];
                    if (idx_q == LAST) state_d = S_COMMIT;
                    else idx_d = idx_q + 4'd1;
                end else begin
                    rem_d   = st_rem;
                    dvd_d   = st_dvd;
                    quo_d   = st_quo;
                    chan_d  = 2'd0;
                    bit_d   = 5'd22;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                rem_d = st_rem;
                dvd_d = st_dvd;
                quo_d = st_quo;
                bit_d = bit_q - 5'd1;
                if (bit_q == 5'd0) state_d = S_WRITE;
            end
            S_WRITE: begin
                shadow_d[idx_q][chan_q*8 +: 8] = sat_q;
                if (chan_q != 2'd2) begin
                    chan_d  = chan_q + 2'd1;
                    rem_d   = 12'd0;
                    dvd_d   = cur_sum;
                    quo_d   = 24'd0;
                    bit_d   = 5'd23;
                    state_d = S_DIV;
                end else if (idx_q == LAST) begin
                    state_d = S_COMMIT;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = S_SCAN;
                end
            end
            S_COMMIT: begin
                mean_d    = shadow_q;
                changed_d = shadow_q != mean_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            chan_q    <= '0;
            bit_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            quo_q     <= '0;
            mean_q    <= '0;
            shadow_q  <= '0;
            en_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            chan_q    <= chan_d;
            bit_q     <= bit_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            quo_q     <= quo_d;
            mean_q    <= mean_d;
            shadow_q  <= shadow_d;
            en_q      <= en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            changed_q <= changed_d;
        end
    end

    assign meanOut = mean_q;
    assign enabled = en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign changed = changed_q;

endmodule

// File: doc/mean_update_engine.md
Name: mean_update_engine

Overview:
- Back end of the k-means iteration loop; the cluster engine accumulates per-cluster pixel sums and counts.
- Reads those per-cluster RGB sums and counts and divides them with a serial restoring divider to produce the next set of cluster means.
- Commits all T means atomically and reports whether any mean changed, so a top-level controller can decide on convergence.
- Also owns the mean register file and the cluster-enable mask, and accepts initial seed means.

Parameters:
T, 16, number of clusters (1..16)

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
start  input  1  pulse: begin one update pass (ignored unless idle)
accumolator  input  72*T  per-cluster sums; cluster i at [i*72 +:72], channel c (0=R,1=G,2=B) at [i*72+c*24 +:24]
counters  input  12*T  per-cluster pixel counts, cluster i at [i*12 +:12]
seed_valid  input  1  write seed_mean into cluster seed_index (idle only)
seed_index  input  4  seed target cluster
seed_mean  input  24  seed RGB, R at [7:0], G [15:8], B [23:16]
seed_clear  input  1  clear all means and enables (idle only)
meanOut  output  16*24  committed means, cluster i at [i*24 +:24], same channel packing as seed_mean; slots >= T read 0
enabled  output  16  cluster enable mask; bits >= T read 0
busy  output  1  update pass in progress
done  output  1  one-cycle pulse when new means are committed
changed  output  1  valid from done onward: 1 if any committed mean differs from its previous value

Behaviour:
- Reset values: meanOut=0, enabled=0, busy=0, done=0, changed=0, internal shadow means=0, FSM=IDLE.
- Reset mid-pass aborts the pass with no commit.
- States:
  - IDLE: start=1 -> SCAN with cluster index 0 and busy=1 from the next cycle.
  - SCAN, cluster i: if enabled[i]=0 or counters[i]=0 -> shadow[i]=meanOut[i], i++ (1 cycle). Else load the divider with channel 0 -> DIV.
  - DIV: 24 cycles, one quotient bit per cycle, MSB first, 24-bit dividend / 12-bit divisor -> WRITE.
  - WRITE (1 cycle): shadow[i][c*8 +:8] = quotient>255 ? 8'hFF : quotient[7:0]. If c<2, c++ and -> DIV. Else i++ and -> SCAN, or -> COMMIT after i=T-1.
  - COMMIT (1 cycle): meanOut<=shadow; changed<=(shadow!=meanOut); done=1 this cycle; busy=0 from the next cycle -> IDLE.
- Latency: done asserts N cycles after the edge that samples start. N = 75*(active clusters) + 1*(skipped clusters) + 1.
- Quotient is truncating: floor(sum/count).
- meanOut is stable for the whole pass and changes only on the COMMIT edge.
- Inputs accumolator and counters must be held stable while busy. The engine does not snapshot them.
- start while busy: ignored. seed_valid or seed_clear while busy: ignored.
- seed_valid in IDLE:
  - seed_index<T: meanOut[seed_index]<=seed_mean, enabled[seed_index]<=1, shadow updated identically.
  - seed_index>=T: ignored.
- seed_clear in IDLE: all means, shadow and enabled <=0; wins over a same-cycle seed_valid.
- start together with a seed write in IDLE: the seed is written on that edge and the pass starts. Skipped clusters carry the newly seeded value.
- changed holds its value until the next COMMIT or reset.

Test Plan:
- Reset, then seed clusters 0..3 with 0x000000, 0x808080, 0xFF0000, 0x00FF00 -> enabled=0x000F, meanOut slots 0..3 match the seeds, busy=0.
- T=16, only cluster 0 enabled, count=3, sums R=767, G=10, B=0, start -> done exactly 91 cycles after start. meanOut[0] R=255, G=3, B=0; changed=1.
- Repeat the same pass with identical inputs -> same meanOut, changed=0, done after 91 cycles.
- Enabled cluster with count=0 and seed 0x123456 -> mean stays 0x123456 and the cluster takes 1 cycle. Sum R=4000, count=1 -> R clamps to 0xFF.
- Assert start, seed_valid and seed_clear repeatedly mid-pass -> all ignored, done timing unchanged. Assert reset at cycle 40 of a pass -> all outputs 0, no done pulse.
- All 16 clusters enabled with count=4095 and sums 4095*{10,20,30} -> done after 1201 cycles. All means 0x1E140A (R=10, G=20, B=30).
